down_counter: RTL and testbench
===============================

DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 Parameter WIDTH, default 7, sets the count width in bits; legal range is 2..16.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; one clock domain only.
REQ-004 load  input  1  load request; cnt and the reload register take load_val.
REQ-005 load_val  input  WIDTH  value to load.
REQ-006 start  input  1  start or resume the countdown.
REQ-007 pause  input  1  freeze the countdown while running.
REQ-008 cnt  output  WIDTH  current count, registered.
REQ-009 busy  output  1  high in RUN or PAUSE, registered.
REQ-010 done  output  1  terminal-count pulse, high for exactly one cycle, registered.

Function
REQ-011 The FSM SHALL have four states: IDLE, RUN, PAUSE and DONE.
REQ-012 Control priority per edge SHALL be rst_n, then load, then start, then pause.
REQ-013 load in any state SHALL set cnt and reload_reg to load_val and state to IDLE at that edge; load in RUN or PAUSE aborts the countdown with no done pulse.
REQ-014 IDLE + start, cnt != 0: SHALL go to RUN; cnt is unchanged on that edge.
REQ-015 IDLE + start, cnt == 0: SHALL go to DONE; cnt stays 0.
REQ-016 RUN: cnt SHALL decrement by 1 on each edge without pause.
REQ-017 RUN: the edge that takes cnt from 1 to 0 SHALL also move the state to DONE.
REQ-018 Latency: with load_val = N > 0 and start sampled at edge E0, cnt SHALL reach 0 and done SHALL be high after edge EN.
REQ-019 cnt SHALL never wrap below 0.
REQ-020 RUN + pause: SHALL go to PAUSE with no decrement on that edge.
REQ-021 PAUSE: cnt SHALL hold; start returns to RUN with no decrement on the resume edge; pause held in PAUSE has no effect.
REQ-022 start in RUN, and pause in IDLE or DONE, SHALL be ignored.
REQ-023 done SHALL equal (state == DONE) and last exactly one cycle.
REQ-024 DONE SHALL leave on the next edge as set by REQ-029/REQ-030 unless load or reset overrides it.
REQ-025 busy SHALL equal (state == RUN or state == PAUSE).

Reset
REQ-026 rst_n low at a rising edge SHALL force: cnt = 0, reload_reg = 0, state = IDLE, busy = 0, done = 0.
REQ-027 Reset SHALL override load, start and pause, including in the middle of RUN, PAUSE or DONE; no done pulse is produced for an aborted count.
REQ-028 After rst_n returns high the block SHALL sit in IDLE until load or start.

Configuration
REQ-029 With macro DOWN_COUNTER_AUTO_RELOAD_EN defined, DONE SHALL go to RUN with cnt = reload_reg when reload_reg != 0, and to IDLE when reload_reg == 0. This gives a periodic done every reload_reg + 1 cycles.
REQ-030 With DOWN_COUNTER_AUTO_RELOAD_EN undefined, DONE SHALL always go to IDLE with cnt = 0; reload_reg still captures load_val but has no other effect.

Verification
REQ-031 Reset then load_val=5, then start -> cnt 5,4,3,2,1,0 on successive edges; done high exactly 1 cycle when cnt=0; busy low in DONE.
REQ-032 load_val=10, start, pause when cnt=6, hold 3 cycles, then start -> cnt holds 6 for the pause cycles, then resumes 5,4,...; total cycles to done = 10 + pause cycles + 1.
REQ-033 Count running at cnt=40 (WIDTH=7, load_val=100), then rst_n low for 1 cycle -> cnt=0, IDLE, busy=0, no done pulse.
REQ-034 load_val=0, start -> done pulses on the next cycle; cnt stays 0 throughout.
REQ-035 Running at cnt=3, load with load_val=127 and start both high -> cnt=127, IDLE, start ignored, no done.
REQ-036 With DOWN_COUNTER_AUTO_RELOAD_EN, load_val=3, start once -> done repeats every 4 cycles with cnt 3,2,1,0,3,2,1,0,...; without the macro -> a single done, then IDLE with cnt=0.

Source files
------------

// File: rtl/down_counter.sv
// down_counter: loadable down counter with IDLE/RUN/PAUSE/DONE control FSM
// Ports: clk, rst_n (sync, active-low), load/load_val (load count and reload value),
//        start (start/resume), pause (freeze while running),
//        cnt (registered count), busy (RUN or PAUSE), done (one-cycle terminal pulse).
// Build option: DOWN_COUNTER_AUTO_RELOAD_EN restarts from the reload value after DONE.
module down_counter #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             busy_q, done_q;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        if (load) begin
            cnt_d    = load_val;
            reload_d = load_val;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = (cnt_q != '0) ? RUN : DONE;
                RUN: begin
                    if (pause) state_d = PAUSE;
                    else begin
                        // saturate at zero; the 1->0 edge also lands in DONE
                        cnt_d = (cnt_q != '0) ? cnt_q - WIDTH'(1) : cnt_q;
                        if (cnt_q <= WIDTH'(1)) state_d = DONE;
                    end
                end
                PAUSE:   if (start) state_d = RUN;
                DONE: begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                    state_d = (reload_q != '0) ? RUN : IDLE;
                    cnt_d   = reload_q;
`else
                    state_d = IDLE;
                    cnt_d   = '0;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end
    // busy/done are registered from the next state so they align with state_q
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            busy_q   <= (state_d == RUN) || (state_d == PAUSE);
            done_q   <= (state_d == DONE);
        end
    end
    assign cnt  = cnt_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: directed self-checking bench for down_counter (WIDTH=7)
module tb_down_counter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [6:0] load_val = '0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [6:0] cnt;
    logic       busy;
    logic       done;
    int         n_checks = 0;
    int         n_fail = 0;

    down_counter #(.WIDTH(7)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .cnt(cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // packs {cnt, busy, done} so one comparison covers all outputs
    function automatic int st(input int c, input bit b, input bit d);
        return (c << 2) | (int'(b) << 1) | int'(d);
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d busy=%0d done=%0d, expected cnt=%0d busy=%0d done=%0d",
                     tag, got >> 2, (got >> 1) & 1, got & 1, exp >> 2, (exp >> 1) & 1, exp & 1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int obs();
        return st(int'(cnt), busy, done);
    endfunction

    initial begin
        // reset
        step();
        check("reset", obs(), st(0, 0, 0));
        rst_n = 1'b1;
        step();
        check("post_reset_idle", obs(), st(0, 0, 0));

        // basic countdown from 5
        load = 1'b1; load_val = 7'd5;
        step();
        load = 1'b0;
        check("load5", obs(), st(5, 0, 0));
        start = 1'b1;
        step();
        start = 1'b0;
        check("start5", obs(), st(5, 1, 0));
        for (int k = 4; k >= 1; k--) begin
            step();
            check($sformatf("run5_cnt%0d", k), obs(), st(k, 1, 0));
        end
        step();
        check("done5", obs(), st(0, 0, 1));
        step();
        check("done5_single", done, 0);

        // pause/resume: 10 with 3 pause cycles at cnt=6
        load = 1'b1; load_val = 7'd10;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        check("start10", obs(), st(10, 1, 0));
        repeat (4) step();
        check("run10_at6", obs(), st(6, 1, 0));
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("pause_hold%0d", k), obs(), st(6, 1, 0));
        end
        pause = 1'b0; start = 1'b1;
        step();
        check("resume_no_dec", obs(), st(6, 1, 0));
        // start stays high for one running edge: ignored in RUN
        step();
        start = 1'b0;
        check("start_in_run_ignored", obs(), st(5, 1, 0));
        for (int k = 4; k >= 1; k--) begin
            step();
            check($sformatf("run10_cnt%0d", k), obs(), st(k, 1, 0));
        end
        step();
        check("done10", obs(), st(0, 0, 1));
        step();

        // reset mid-run at cnt=40
        load = 1'b1; load_val = 7'd100;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (60) step();
        check("run100_at40", obs(), st(40, 1, 0));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_run_reset", obs(), st(0, 0, 0));
        step();
        check("after_reset_idle", obs(), st(0, 0, 0));

        // zero load: immediate done
        load = 1'b1; load_val = 7'd0;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        check("zero_done", obs(), st(0, 0, 1));
        step();
        check("zero_after", obs(), st(0, 0, 0));

        // load beats start while running at cnt=3
        load = 1'b1; load_val = 7'd20;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (17) step();
        check("run20_at3", obs(), st(3, 1, 0));
        load = 1'b1; load_val = 7'd127; start = 1'b1;
        step();
        load = 1'b0; start = 1'b0;
        check("load_abort", obs(), st(127, 0, 0));
        step();
        check("load_abort_idle", obs(), st(127, 0, 0));
        pause = 1'b1;
        step();
        pause = 1'b0;
        check("pause_in_idle_ignored", obs(), st(127, 0, 0));

        // DONE exit behaviour with load_val=3
        load = 1'b1; load_val = 7'd3;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        check("start3", obs(), st(3, 1, 0));
        step();
        check("run3_cnt2", obs(), st(2, 1, 0));
        step();
        check("run3_cnt1", obs(), st(1, 1, 0));
        step();
        check("done3", obs(), st(0, 0, 1));
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        for (int r = 0; r < 2; r++) begin
            step();
            check($sformatf("reload%0d_cnt3", r), obs(), st(3, 1, 0));
            step();
            check($sformatf("reload%0d_cnt2", r), obs(), st(2, 1, 0));
            step();
            check($sformatf("reload%0d_cnt1", r), obs(), st(1, 1, 0));
            step();
            check($sformatf("reload%0d_done", r), obs(), st(0, 0, 1));
        end
`else
        step();
        check("done3_to_idle", obs(), st(0, 0, 0));
        step();
        check("idle_stays", obs(), st(0, 0, 0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
